// File: rtl/crc_checker.sv
// Receive-side CRC-16/CCITT-FALSE checker: the last two bytes of each message are the CRC.
// Optional statistics counters (err_cnt, msg_cnt) are enabled by defining CRC_CHK_STAT_EN.
module crc_checker (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        msg_start,
  input  logic [7:0]  d,
  input  logic        d_rdy,
  input  logic        msg_end,
  output logic        busy,
  output logic        chk_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        short_msg,
  output logic [15:0] rx_crc,
`ifdef CRC_CHK_STAT_EN
  output logic [7:0]  err_cnt,
  output logic [7:0]  msg_cnt,
`endif
  output logic [15:0] calc_crc
);

  typedef enum logic [1:0] {StIdle, StRx, StCheck, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  b1_q, b1_d, b0_q, b0_d;
  logic [1:0]  fill_q, fill_d;
  logic [15:0] rx_crc_q, rx_crc_d;
  logic        ok_q, ok_d, err_q, err_d, short_q, short_d;
  logic        pend_q, pend_d;
  logic        restart, accept, match;

  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    b1_d     = b1_q;
    b0_d     = b0_q;
    fill_d   = fill_q;
    rx_crc_d = rx_crc_q;
    ok_d     = ok_q;
    err_d    = err_q;
    short_d  = short_q;
    pend_d   = pend_q;
    restart  = 1'b0;
    accept   = 1'b0;
    match    = ({b1_q, b0_q} == crc_q);

    unique case (state_q)
      StIdle: begin
        restart = msg_start;
        accept  = msg_start && d_rdy;
      end
      StRx: begin
        if (msg_start) begin
          restart = 1'b1;
          accept  = d_rdy;
        end else begin
          accept = d_rdy;
          if (msg_end) state_d = StCheck;
        end
      end
      StCheck: begin
        if (msg_start) pend_d = 1'b1;
        rx_crc_d = {b1_q, b0_q};
        ok_d     = (fill_q == 2'd2) && match;
        err_d    = !((fill_q == 2'd2) && match);
        short_d  = (fill_q < 2'd2);
        state_d  = StDone;
      end
      StDone: begin
        // A start seen during CHECK/DONE opens the next message here; its byte is dropped.
        if (pend_q || msg_start) restart = 1'b1;
        else                     state_d = StIdle;
      end
    endcase

    if (restart) begin
      state_d = StRx;
      crc_d   = 16'hFFFF;
      b1_d    = 8'h00;
      b0_d    = 8'h00;
      fill_d  = 2'd0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      short_d = 1'b0;
      pend_d  = 1'b0;
    end

    // Byte shifts through the 2-byte delay line; the oldest byte enters the CRC once full.
    if (accept) begin
      if (fill_d == 2'd2) crc_d = crc_byte(crc_d, b1_d);
      else                fill_d = fill_d + 2'd1;
      b1_d = b0_d;
      b0_d = d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      crc_q    <= 16'hFFFF;
      b1_q     <= 8'h00;
      b0_q     <= 8'h00;
      fill_q   <= 2'd0;
      rx_crc_q <= 16'h0000;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      short_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      b1_q     <= b1_d;
      b0_q     <= b0_d;
      fill_q   <= fill_d;
      rx_crc_q <= rx_crc_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      short_q  <= short_d;
      pend_q   <= pend_d;
    end
  end

  assign busy      = (state_q == StRx) || (state_q == StCheck);
  assign chk_done  = (state_q == StDone);
  assign crc_ok    = ok_q;
  assign crc_err   = err_q;
  assign short_msg = short_q;
  assign rx_crc    = rx_crc_q;
  assign calc_crc  = crc_q;

`ifdef CRC_CHK_STAT_EN
  logic [7:0] err_cnt_q, msg_cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_cnt_q <= 8'h00;
      msg_cnt_q <= 8'h00;
    end else if (chk_done) begin
      if (msg_cnt_q != 8'hFF)           msg_cnt_q <= msg_cnt_q + 8'h01;
      if (err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_cnt = err_cnt_q;
  assign msg_cnt = msg_cnt_q;
`endif

endmodule
